// File: rtl/pc_ir_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// pc_ir_fetch_unit_if
// Bus between the control unit / datapath and the PC/IR fetch unit.
//
// Signals (master = control unit side, slave = fetch unit side):
//   processor_enable           m->s  gates all functional updates
//   PC_write_enable            m->s  load PC from the PC mux
//   PC_mux_select[1:0]         m->s  00 PC+1, 01 ACC, 10 PC-3, 11 PC+2
//   IR_load_enable             m->s  load IR from mem_rdata
//   Memory_address_mux_select  m->s  00 IR, 01 ACC, 10/11 PC
//   acc                        m->s  accumulator value
//   mem_rdata                  m->s  memory read data
//   mem_addr                   s->m  combinational memory address
//   pc                         s->m  current program counter
//   instruction                s->m  current IR contents
//   ir_valid                   s->m  IR holds a fetched or scanned-in value
//   pc_wrapped                 s->m  sticky PC wrap flag
// -----------------------------------------------------------------------------
interface pc_ir_fetch_unit_if #(
    parameter int PC_WIDTH    = 5,
    parameter int INSTR_WIDTH = 8
);
    logic                   processor_enable;
    logic                   PC_write_enable;
    logic [1:0]             PC_mux_select;
    logic                   IR_load_enable;
    logic [1:0]             Memory_address_mux_select;
    logic [INSTR_WIDTH-1:0] acc;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic [PC_WIDTH-1:0]    mem_addr;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   ir_valid;
    logic                   pc_wrapped;

    modport master (
        output processor_enable,
        output PC_write_enable,
        output PC_mux_select,
        output IR_load_enable,
        output Memory_address_mux_select,
        output acc,
        output mem_rdata,
        input  mem_addr,
        input  pc,
        input  instruction,
        input  ir_valid,
        input  pc_wrapped
    );

    modport slave (
        input  processor_enable,
        input  PC_write_enable,
        input  PC_mux_select,
        input  IR_load_enable,
        input  Memory_address_mux_select,
        input  acc,
        input  mem_rdata,
        output mem_addr,
        output pc,
        output instruction,
        output ir_valid,
        output pc_wrapped
    );
endinterface

// File: rtl/pc_ir_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_ir_fetch_unit
// Program counter and instruction register for the qtcore datapath. Applies
// the PC / IR / memory-address strobes from the control unit, drives the
// current instruction back to it, and forms one scan chain segment
// (scan_in -> PC[0..PC_WIDTH-1] -> IR[0..INSTR_WIDTH-1] -> scan_out).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   bus          pc_ir_fetch_unit_if.slave (strobes, acc, memory bus, state)
//   scan_enable  scan shift enable (priority over functional updates)
//   scan_in      scan serial in
//   scan_out     scan serial out (IR MSB, combinational)
//
// Optional feature macro: PC_WRAP_FLAG_EN
//   defined   : bus.pc_wrapped is a sticky flag set by any functional PC
//               write whose +1 / +2 / -3 arithmetic crossed the 0/max boundary
//   undefined : bus.pc_wrapped is tied to 0
// -----------------------------------------------------------------------------
module pc_ir_fetch_unit #(
    parameter int PC_WIDTH    = 5,
    parameter int INSTR_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    pc_ir_fetch_unit_if.slave  bus,
    input  logic               scan_enable,
    input  logic               scan_in,
    output logic               scan_out
);

    localparam int CHAIN_W = PC_WIDTH + INSTR_WIDTH;

    localparam logic [PC_WIDTH:0] K_ONE   = (PC_WIDTH+1)'(1);
    localparam logic [PC_WIDTH:0] K_TWO   = (PC_WIDTH+1)'(2);
    localparam logic [PC_WIDTH:0] K_THREE = (PC_WIDTH+1)'(3);

    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   ir_valid_q, ir_valid_d;

    // One extra bit on each adder holds the carry/borrow used for wrap detect.
    logic [PC_WIDTH:0]      pc_plus1;
    logic [PC_WIDTH:0]      pc_plus2;
    logic [PC_WIDTH:0]      pc_minus3;
    logic [PC_WIDTH-1:0]    pc_sel;
    logic                   pc_sel_wraps;

    logic [CHAIN_W-1:0]     chain_cur;
    logic [CHAIN_W-1:0]     chain_nxt;

    logic                   func_active;

    assign func_active = !scan_enable && bus.processor_enable;

    // ---------------------------------------------------------------------
    // PC mux
    // ---------------------------------------------------------------------
    always_comb begin
        pc_plus1     = {1'b0, pc_q} + K_ONE;
        pc_plus2     = {1'b0, pc_q} + K_TWO;
        pc_minus3    = {1'b0, pc_q} - K_THREE;
        pc_sel       = pc_plus1[PC_WIDTH-1:0];
        pc_sel_wraps = 1'b0;
        case (bus.PC_mux_select)
            2'b00: begin
                pc_sel       = pc_plus1[PC_WIDTH-1:0];
                pc_sel_wraps = pc_plus1[PC_WIDTH];
            end
            2'b01: begin
                pc_sel       = bus.acc[PC_WIDTH-1:0];
                pc_sel_wraps = 1'b0;
            end
            2'b10: begin
                pc_sel       = pc_minus3[PC_WIDTH-1:0];
                pc_sel_wraps = pc_minus3[PC_WIDTH];
            end
            2'b11: begin
                pc_sel       = pc_plus2[PC_WIDTH-1:0];
                pc_sel_wraps = pc_plus2[PC_WIDTH];
            end
            default: begin
                pc_sel       = pc_plus1[PC_WIDTH-1:0];
                pc_sel_wraps = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Scan chain: PC sits at the low end, IR MSB is the chain tail.
    // ---------------------------------------------------------------------
    assign chain_cur = {ir_q, pc_q};
    assign chain_nxt = {chain_cur[CHAIN_W-2:0], scan_in};
    assign scan_out  = ir_q[INSTR_WIDTH-1];

    // ---------------------------------------------------------------------
    // Next-state
    // ---------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (scan_enable) begin
            {ir_d, pc_d} = chain_nxt;
            ir_valid_d   = 1'b1;
        end else if (bus.processor_enable) begin
            // IR captures data addressed by the pre-update PC, so a fetch
            // cycle is IR load and PC+1 together.
            if (bus.PC_write_enable) begin
                pc_d = pc_sel;
            end
            if (bus.IR_load_enable) begin
                ir_d       = bus.mem_rdata;
                ir_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // ---------------------------------------------------------------------
    // Optional sticky wrap flag (kept outside the scan chain)
    // ---------------------------------------------------------------------
`ifdef PC_WRAP_FLAG_EN
    logic pc_wrapped_q, pc_wrapped_d;

    always_comb begin
        pc_wrapped_d = pc_wrapped_q;
        if (func_active && bus.PC_write_enable && pc_sel_wraps) begin
            pc_wrapped_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_wrapped_q <= 1'b0;
        end else begin
            pc_wrapped_q <= pc_wrapped_d;
        end
    end

    assign bus.pc_wrapped = pc_wrapped_q;
`else
    logic unused_wrap;
    assign unused_wrap    = pc_sel_wraps & func_active;
    assign bus.pc_wrapped = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Memory address mux, combinational from registered state and acc
    // ---------------------------------------------------------------------
    always_comb begin
        case (bus.Memory_address_mux_select)
            2'b00:   bus.mem_addr = ir_q[PC_WIDTH-1:0];
            2'b01:   bus.mem_addr = bus.acc[PC_WIDTH-1:0];
            default: bus.mem_addr = pc_q;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.instruction = ir_q;
    assign bus.ir_valid    = ir_valid_q;

    // Upper accumulator bits only matter to the rest of the datapath.
    logic unused_acc_hi;
    assign unused_acc_hi = ^bus.acc[INSTR_WIDTH-1:PC_WIDTH];

endmodule

// File: tb/tb_pc_ir_fetch_unit.sv
module tb_pc_ir_fetch_unit;

    localparam int PW = 5;
    localparam int IW = 8;

    logic clk;
    logic rst;
    logic se;
    logic si;
    logic so;

    pc_ir_fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

    pc_ir_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .scan_enable (se),
        .scan_in     (si),
        .scan_out    (so)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int pc;
        int ir;
        int valid;
        int wrapped;
        int addr;
        int sout;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    int m_pc = 0;
    int m_ir = 0;
    int m_valid = 0;
    int m_wrap = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model step for one posedge, using the inputs this bench is driving.
    task automatic model_step();
        int t;
        int chain;
        if (!rst) begin
            m_pc = 0; m_ir = 0; m_valid = 0; m_wrap = 0;
        end else if (se) begin
            chain   = m_ir * 32 + m_pc;
            chain   = (chain * 2 + int'(si)) % 8192;
            m_pc    = chain % 32;
            m_ir    = chain / 32;
            m_valid = 1;
        end else if (bus.processor_enable) begin
            if (bus.PC_write_enable) begin
                case (bus.PC_mux_select)
                    2'd0:    t = m_pc + 1;
                    2'd1:    t = int'(bus.acc) % 32;
                    2'd2:    t = m_pc - 3;
                    default: t = m_pc + 2;
                endcase
`ifdef PC_WRAP_FLAG_EN
                if (bus.PC_mux_select != 2'd1 && (t > 31 || t < 0)) m_wrap = 1;
`endif
                m_pc = (t + 32) % 32;
            end
            if (bus.IR_load_enable) begin
                m_ir    = int'(bus.mem_rdata);
                m_valid = 1;
            end
        end
    endtask

    function automatic int model_addr();
        case (bus.Memory_address_mux_select)
            2'd0:    return m_ir % 32;
            2'd1:    return int'(bus.acc) % 32;
            default: return m_pc;
        endcase
    endfunction

    // Inputs are applied before the call; one clock, model update, expectation push.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_step();
        e.pc      = m_pc;
        e.ir      = m_ir;
        e.valid   = m_valid;
        e.wrapped = m_wrap;
        e.addr    = model_addr();
        e.sout    = (m_ir / 128) % 2;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Monitor: the unit presents new state every clock; compare on the far edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mon_pc",       32'(bus.pc),          32'(e.pc));
            chk("mon_ir",       32'(bus.instruction), 32'(e.ir));
            chk("mon_ir_valid", 32'(bus.ir_valid),    32'(e.valid));
            chk("mon_wrapped",  32'(bus.pc_wrapped),  32'(e.wrapped));
            chk("mon_mem_addr", 32'(bus.mem_addr),    32'(e.addr));
            chk("mon_scan_out", 32'(so),              32'(e.sout));
        end
    end

    task automatic scan_load(input int pcv, input int irv);
        int chain;
        chain = irv * 32 + pcv;
        se = 1'b1;
        for (int i = 12; i >= 0; i--) begin
            si = 1'((chain >> i) & 1);
            cycle();
        end
        se = 1'b0;
        si = 1'b0;
    endtask

    task automatic scan_unload(output int got);
        got = 0;
        se  = 1'b1;
        si  = 1'b0;
        for (int i = 0; i < 13; i++) begin
            got = got * 2 + int'(so);
            cycle();
        end
        se = 1'b0;
    endtask

    task automatic set_func(input logic en, input logic we, input logic [1:0] psel,
                            input logic ld, input logic [1:0] asel);
        bus.processor_enable          = en;
        bus.PC_write_enable           = we;
        bus.PC_mux_select             = psel;
        bus.IR_load_enable            = ld;
        bus.Memory_address_mux_select = asel;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int got;
    int wrap_exp;

    initial begin
`ifdef PC_WRAP_FLAG_EN
        wrap_exp = 1;
`else
        wrap_exp = 0;
`endif
        rst = 1'b0; se = 1'b0; si = 1'b0;
        set_func(1'b0, 1'b0, 2'b00, 1'b0, 2'b10);
        bus.acc = 8'h00;
        bus.mem_rdata = 8'h00;

        // reset
        cycle(); cycle();
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_ir", 32'(bus.instruction), 32'd0);
        chk("rst_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_wrapped", 32'(bus.pc_wrapped), 32'd0);

        // fetch
        rst = 1'b1;
        set_func(1'b1, 1'b1, 2'b00, 1'b1, 2'b10);
        bus.mem_rdata = 8'h45;
        cycle();
        chk("fetch_ir", 32'(bus.instruction), 32'h45);
        chk("fetch_valid", 32'(bus.ir_valid), 32'd1);
        chk("fetch_pc", 32'(bus.pc), 32'd1);
        chk("fetch_addr", 32'(bus.mem_addr), 32'd1);

        // branches
        set_func(1'b1, 1'b0, 2'b00, 1'b0, 2'b10);
        scan_load(4, 8'h11);
        set_func(1'b1, 1'b1, 2'b11, 1'b0, 2'b10);
        cycle();
        chk("br_plus2", 32'(bus.pc), 32'd6);
        set_func(1'b1, 1'b1, 2'b10, 1'b0, 2'b10);
        cycle();
        chk("br_minus3", 32'(bus.pc), 32'd3);
        set_func(1'b1, 1'b0, 2'b10, 1'b0, 2'b10);
        cycle();
        chk("br_hold", 32'(bus.pc), 32'd3);
        chk("br_nowrap", 32'(bus.pc_wrapped), 32'd0);

        // wrap boundaries
        set_func(1'b1, 1'b0, 2'b00, 1'b0, 2'b10);
        scan_load(31, 8'h00);
        set_func(1'b1, 1'b1, 2'b00, 1'b0, 2'b10);
        cycle();
        chk("wrap_inc", 32'(bus.pc), 32'd0);
        chk("wrap_flag_set", 32'(bus.pc_wrapped), 32'(wrap_exp));
        set_func(1'b1, 1'b0, 2'b00, 1'b0, 2'b10);
        scan_load(1, 8'h00);
        set_func(1'b1, 1'b1, 2'b10, 1'b0, 2'b10);
        cycle();
        chk("wrap_dec", 32'(bus.pc), 32'd30);
        set_func(1'b1, 1'b1, 2'b11, 1'b0, 2'b10);
        cycle();
        chk("wrap_plus2_30", 32'(bus.pc), 32'd0);
        set_func(1'b1, 1'b1, 2'b10, 1'b0, 2'b10);
        cycle();
        chk("wrap_dec_0", 32'(bus.pc), 32'd29);
        chk("wrap_flag_sticky", 32'(bus.pc_wrapped), 32'(wrap_exp));
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("wrap_flag_clr", 32'(bus.pc_wrapped), 32'd0);

        // jump / LDAR addressing (acc loads never flag a wrap)
        bus.acc = 8'hE7;
        set_func(1'b1, 1'b1, 2'b01, 1'b0, 2'b10);
        cycle();
        chk("jmp_pc", 32'(bus.pc), 32'd7);
        chk("jmp_nowrap", 32'(bus.pc_wrapped), 32'd0);
        set_func(1'b1, 1'b0, 2'b01, 1'b0, 2'b01);
        #1;
        chk("ldar_addr", 32'(bus.mem_addr), 32'd7);
        set_func(1'b1, 1'b0, 2'b00, 1'b0, 2'b10);
        scan_load(7, 8'h3A);
        set_func(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        #1;
        chk("ir_addr", 32'(bus.mem_addr), 32'h1A);

        // scan with functional strobes held active
        bus.mem_rdata = 8'hFF;
        set_func(1'b1, 1'b1, 2'b00, 1'b1, 2'b10);
        scan_load(5'h15, 8'hA5);
        chk("scan_pc", 32'(bus.pc), 32'h15);
        chk("scan_ir", 32'(bus.instruction), 32'hA5);
        chk("scan_valid", 32'(bus.ir_valid), 32'd1);
        scan_unload(got);
        chk("scan_unload", 32'(got), 32'h14B5);

        // enable low, all strobes high
        set_func(1'b1, 1'b0, 2'b00, 1'b0, 2'b10);
        scan_load(9, 8'h5C);
        bus.acc = 8'h13; bus.mem_rdata = 8'hC3;
        set_func(1'b0, 1'b1, 2'b01, 1'b1, 2'b10);
        cycle(); cycle();
        chk("en_pc_hold", 32'(bus.pc), 32'd9);
        chk("en_ir_hold", 32'(bus.instruction), 32'h5C);

        // reset beats scan, and discards an in-flight fetch
        rst = 1'b0; se = 1'b1; si = 1'b1;
        set_func(1'b1, 1'b1, 2'b00, 1'b1, 2'b10);
        cycle();
        chk("rstscan_pc", 32'(bus.pc), 32'd0);
        chk("rstscan_ir", 32'(bus.instruction), 32'd0);
        chk("rstscan_valid", 32'(bus.ir_valid), 32'd0);
        rst = 1'b1; se = 1'b0; si = 1'b0;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            se  = ($urandom_range(0, 7) == 0);
            si  = 1'($urandom);
            set_func(($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom),
                     1'($urandom), 2'($urandom));
            bus.acc       = 8'($urandom);
            bus.mem_rdata = 8'($urandom);
            cycle();
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
